writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  Final pipeline stage: accepts retiring results from execute, waits for load data when needed,
//  aligns and sign/zero-extends loads, and drives the register file write port one cycle later.
//  Sits between the execute/memory stage and regfile (write_i/waddr_i/wdata_i).
// PARAMETERS
//  TIMEOUT_CYCLES  255  load-response watchdog limit in cycles; used only with WB_TIMEOUT_EN
// PORTS
//  clk_i          in   1   clock, all state updates on posedge
//  rst_i          in   1   synchronous reset, active-high
//  ex_valid_i     in   1   execute presents a retiring instruction
//  ex_ready_o     out  1   stage can accept; transfer occurs when ex_valid_i & ex_ready_o
//  ex_rd_i        in   5   destination register index
//  ex_result_i    in   32  ALU result (non-load) or unused (load)
//  ex_is_load_i   in   1   instruction is a load
//  ex_funct3_i    in   3   load width/sign: LB=000 LH=001 LW=010 LBU=100 LHU=101
//  ex_addr_lo_i   in   2   load byte address bits [1:0]
//  mem_rvalid_i   in   1   load data valid (single-cycle pulse)
//  mem_rdata_i    in   32  aligned 32-bit word containing load data
//  rf_write_o     out  1   regfile write enable (registered)
//  rf_waddr_o     out  5   regfile write index (registered)
//  rf_wdata_o     out  32  regfile write data (registered)
//  retire_o       out  1   one-cycle pulse per completed instruction (incl. rd=0, errors)
//  err_o          out  1   one-cycle pulse with retire_o: misaligned/illegal load or timeout
// BEHAVIOUR
//  Reset: state=IDLE; rf_write_o=0, rf_waddr_o=0, rf_wdata_o=0, retire_o=0, err_o=0; ex_ready_o=1.
//  States: IDLE, WAIT_MEM. ex_ready_o = (state==IDLE), purely from state, no combinational path from inputs.
//  IDLE, transfer of non-load at cycle N: cycle N+1 rf_write_o=(rd!=0), rf_waddr_o=rd,
//   rf_wdata_o=ex_result_i, retire_o=1. Stay IDLE; back-to-back transfers give 1 result/cycle.
//  IDLE, transfer of load: latch rd, funct3, addr_lo; go WAIT_MEM. No output pulse.
//  Load check at acceptance: funct3 in {011,110,111} illegal; LH/LHU with addr_lo[0]=1 or
//   LW with addr_lo!=0 misaligned. Flagged loads still wait for mem_rvalid_i, then retire
//   with err_o=1, rf_write_o=0.
//  WAIT_MEM: on mem_rvalid_i at cycle M -> cycle M+1 write aligned value (rd!=0, no error),
//   retire_o=1; state IDLE at M+1 (next transfer accepted at M+1 earliest).
//  Alignment: byte = rdata[8*addr_lo +: 8], half = rdata[16*addr_lo[1] +: 16];
//   LB/LH sign-extend to 32, LBU/LHU zero-extend, LW passes word.
//  mem_rvalid_i in IDLE ignored; response never required in the acceptance cycle.
//  Outputs not pulsed hold rf_write_o=0, retire_o=0, err_o=0; rf_waddr_o/rf_wdata_o hold last value.
//  rd=0: never writes, still retires (rf_waddr_o still updated to 0).
//  Reset mid-load (WAIT_MEM): abandon load, no write, IDLE next cycle; late mem_rvalid_i ignored.
// CONFIGURATION
//  WB_TIMEOUT_EN defined: counter cleared on entering WAIT_MEM, increments each WAIT_MEM cycle
//   without mem_rvalid_i; when count reaches TIMEOUT_CYCLES-1 without response, next cycle
//   retire_o=1, err_o=1, rf_write_o=0, state IDLE. mem_rvalid_i on the limit cycle wins.
//  WB_TIMEOUT_EN undefined: no counter, WAIT_MEM held indefinitely; TIMEOUT_CYCLES unused.
// STRUCTURE
//  rv32i_pkg: localparams for load funct3 encodings (F3_LB..F3_LHU), typedef enum wb_state_t.
//  Sub-module load_align (combinational): funct3 + addr_lo + word -> 32-bit extended value and
//   misaligned/illegal flag; reused by later store/LSU checks.
// TESTING
//  ADD rd=5 result 0xDEADBEEF at N -> N+1 rf_write_o=1, waddr=5, wdata=0xDEADBEEF, retire_o=1.
//  LB rd=3 addr_lo=2, rdata=0x1280_7F00 two cycles later -> wdata=0xFFFFFF80; LBU -> 0x00000080.
//  LH rd=4 addr_lo=2, rdata=0x8001_0000 -> 0xFFFF8001; ex_ready_o=0 throughout WAIT_MEM.
//  LW addr_lo=1 rd=6 -> on response retire_o=1, err_o=1, rf_write_o=0; rd=0 ADD -> no write, retire.
//  rst_i during WAIT_MEM then mem_rvalid_i next cycle -> no write, no retire, ex_ready_o=1.
//  WB_TIMEOUT_EN, TIMEOUT_CYCLES=4, load with no response -> err_o=1 and IDLE after 4 cycles.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings and writeback state type.
// Load funct3 values are reused by the load alignment and later LSU checks.
package rv32i_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: selects the byte/half/word from an aligned
// 32-bit word, sign/zero-extends it, and flags misaligned or illegal loads.
module load_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] word_i,
  output logic [31:0] value_o,
  output logic        fault_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    shifted  = word_i >> {addr_lo_i, 3'b000};
    byte_val = shifted[7:0];
    half_val = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    value_o  = word_i;
    fault_o  = 1'b0;
    case (funct3_i)
      F3_LB:  value_o = {{24{byte_val[7]}}, byte_val};
      F3_LBU: value_o = {24'h000000, byte_val};
      F3_LH: begin
        value_o = {{16{half_val[15]}}, half_val};
        fault_o = addr_lo_i[0];
      end
      F3_LHU: begin
        value_o = {16'h0000, half_val};
        fault_o = addr_lo_i[0];
      end
      F3_LW:   fault_o = (addr_lo_i != 2'b00);
      default: fault_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU results and loads into the register file write port.
// Optional load-response watchdog enabled by defining WB_TIMEOUT_EN.
module writeback_stage
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [4:0]  ex_rd_i,
  input  logic [31:0] ex_result_i,
  input  logic        ex_is_load_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic [1:0]  ex_addr_lo_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        rf_write_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        retire_o,
  output logic        err_o
);

  wb_state_t   state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        fault_q, fault_d;
  logic        rf_write_q, rf_write_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        retire_q, retire_d;
  logic        err_q, err_d;

  logic        accept_fault;
  logic [31:0] unused_accept_value;
  logic [31:0] load_value;
  logic        unused_resp_fault;
  logic        timeout;

  // Fault is judged on the incoming fields; data is aligned later from the latched fields.
  load_align u_accept_chk (
    .funct3_i  (ex_funct3_i),
    .addr_lo_i (ex_addr_lo_i),
    .word_i    (32'h0000_0000),
    .value_o   (unused_accept_value),
    .fault_o   (accept_fault)
  );

  load_align u_resp_align (
    .funct3_i  (funct3_q),
    .addr_lo_i (addr_lo_q),
    .word_i    (mem_rdata_i),
    .value_o   (load_value),
    .fault_o   (unused_resp_fault)
  );

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout = (cnt_q == CNT_LIMIT);

  // Held at zero while idle so every load starts counting from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (!mem_rvalid_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    funct3_d   = funct3_q;
    addr_lo_d  = addr_lo_q;
    fault_d    = fault_q;
    rf_write_d = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    retire_d   = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid_i) begin
          if (ex_is_load_i) begin
            rd_d      = ex_rd_i;
            funct3_d  = ex_funct3_i;
            addr_lo_d = ex_addr_lo_i;
            fault_d   = accept_fault;
            state_d   = WAIT_MEM;
          end else begin
            rf_write_d = (ex_rd_i != 5'd0);
            rf_waddr_d = ex_rd_i;
            rf_wdata_d = ex_result_i;
            retire_d   = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        // A response on the watchdog limit cycle takes priority over the timeout.
        if (mem_rvalid_i) begin
          rf_write_d = !fault_q && (rd_q != 5'd0);
          rf_waddr_d = rd_q;
          if (!fault_q) begin
            rf_wdata_d = load_value;
          end
          retire_d = 1'b1;
          err_d    = fault_q;
          state_d  = IDLE;
        end else if (timeout) begin
          rf_waddr_d = rd_q;
          retire_d   = 1'b1;
          err_d      = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rd_q       <= 5'd0;
      funct3_q   <= 3'b000;
      addr_lo_q  <= 2'b00;
      fault_q    <= 1'b0;
      rf_write_q <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'h0000_0000;
      retire_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      addr_lo_q  <= addr_lo_d;
      fault_q    <= fault_d;
      rf_write_q <= rf_write_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      retire_q   <= retire_d;
      err_q      <= err_d;
    end
  end

  assign ex_ready_o = (state_q == IDLE);
  assign rf_write_o = rf_write_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign retire_o   = retire_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage; observed bundle is
// {ex_ready, rf_write, rf_waddr, rf_wdata, retire, err}.
module tb_writeback_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ex_valid_i = 1'b0;
  logic        ex_ready_o;
  logic [4:0]  ex_rd_i = 5'd0;
  logic [31:0] ex_result_i = 32'h0;
  logic        ex_is_load_i = 1'b0;
  logic [2:0]  ex_funct3_i = 3'b000;
  logic [1:0]  ex_addr_lo_i = 2'b00;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        rf_write_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        retire_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  logic [40:0] obs;
  logic [40:0] exp_v;

  assign obs = {ex_ready_o, rf_write_o, rf_waddr_o, rf_wdata_o, retire_o, err_o};

  writeback_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ex_valid_i   (ex_valid_i),
    .ex_ready_o   (ex_ready_o),
    .ex_rd_i      (ex_rd_i),
    .ex_result_i  (ex_result_i),
    .ex_is_load_i (ex_is_load_i),
    .ex_funct3_i  (ex_funct3_i),
    .ex_addr_lo_i (ex_addr_lo_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .rf_write_o   (rf_write_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o),
    .retire_o     (retire_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] result);
    ex_valid_i   = 1'b1;
    ex_is_load_i = 1'b0;
    ex_rd_i      = rd;
    ex_result_i  = result;
  endtask

  task automatic go_idle();
    ex_valid_i   = 1'b0;
    ex_is_load_i = 1'b0;
    mem_rvalid_i = 1'b0;
  endtask

  task automatic accept_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] addr);
    ex_valid_i   = 1'b1;
    ex_is_load_i = 1'b1;
    ex_rd_i      = rd;
    ex_funct3_i  = f3;
    ex_addr_lo_i = addr;
    ex_result_i  = 32'h5555_5555;
    tick();
    go_idle();
  endtask

  task automatic respond(input logic [31:0] rdata);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    tick();
    mem_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    go_idle();
    tick();
    tick();
    exp_v = {1'b1, 1'b0, 5'd0, 32'h0000_0000, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL reset got %h want %h", obs, exp_v); end
    rst_i = 1'b0;
  endtask

  task automatic test_alu();
    drive_alu(5'd5, 32'hDEAD_BEEF);
    tick();
    exp_v = {1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL add_rd5 got %h want %h", obs, exp_v); end
    go_idle();
    tick();
    exp_v = {1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL add_hold got %h want %h", obs, exp_v); end
  endtask

  task automatic test_back_to_back();
    drive_alu(5'd1, 32'h0000_0011);
    tick();
    exp_v = {1'b1, 1'b1, 5'd1, 32'h0000_0011, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL b2b_0 got %h want %h", obs, exp_v); end
    drive_alu(5'd2, 32'h0000_0022);
    tick();
    exp_v = {1'b1, 1'b1, 5'd2, 32'h0000_0022, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL b2b_1 got %h want %h", obs, exp_v); end
    drive_alu(5'd0, 32'h0000_0033);
    tick();
    exp_v = {1'b1, 1'b0, 5'd0, 32'h0000_0033, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL b2b_rd0 got %h want %h", obs, exp_v); end
    go_idle();
    tick();
    exp_v = {1'b1, 1'b0, 5'd0, 32'h0000_0033, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL b2b_idle got %h want %h", obs, exp_v); end
  endtask

  task automatic test_rvalid_idle();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hFFFF_FFFF;
    tick();
    mem_rvalid_i = 1'b0;
    exp_v = {1'b1, 1'b0, 5'd0, 32'h0000_0033, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL rvalid_idle got %h want %h", obs, exp_v); end
  endtask

  task automatic test_load_byte();
    accept_load(5'd3, 3'b000, 2'd2);
    exp_v = {1'b0, 1'b0, 5'd0, 32'h0000_0033, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL lb_wait0 got %h want %h", obs, exp_v); end
    tick();
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL lb_wait1 got %h want %h", obs, exp_v); end
    respond(32'h1280_7F00);
    exp_v = {1'b1, 1'b1, 5'd3, 32'hFFFF_FF80, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL lb_data got %h want %h", obs, exp_v); end
    accept_load(5'd3, 3'b100, 2'd2);
    respond(32'h1280_7F00);
    exp_v = {1'b1, 1'b1, 5'd3, 32'h0000_0080, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL lbu_data got %h want %h", obs, exp_v); end
    drive_alu(5'd7, 32'h0000_1234);
    tick();
    go_idle();
    exp_v = {1'b1, 1'b1, 5'd7, 32'h0000_1234, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL load_then_alu got %h want %h", obs, exp_v); end
  endtask

  task automatic test_load_half_word();
    accept_load(5'd4, 3'b001, 2'd2);
    exp_v = {1'b0, 1'b0, 5'd7, 32'h0000_1234, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL lh_wait got %h want %h", obs, exp_v); end
    tick();
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL lh_wait1 got %h want %h", obs, exp_v); end
    respond(32'h8001_0000);
    exp_v = {1'b1, 1'b1, 5'd4, 32'hFFFF_8001, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL lh_data got %h want %h", obs, exp_v); end
    accept_load(5'd4, 3'b101, 2'd0);
    respond(32'h0000_F00D);
    exp_v = {1'b1, 1'b1, 5'd4, 32'h0000_F00D, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL lhu_data got %h want %h", obs, exp_v); end
    accept_load(5'd7, 3'b010, 2'd0);
    respond(32'hCAFE_F00D);
    exp_v = {1'b1, 1'b1, 5'd7, 32'hCAFE_F00D, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL lw_data got %h want %h", obs, exp_v); end
    accept_load(5'd8, 3'b000, 2'd0);
    respond(32'hAAAA_AA7F);
    exp_v = {1'b1, 1'b1, 5'd8, 32'h0000_007F, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL lb_pos got %h want %h", obs, exp_v); end
  endtask

  task automatic test_load_error();
    accept_load(5'd6, 3'b010, 2'd1);
    respond(32'h1111_1111);
    exp_v = {1'b1, 1'b0, 5'd6, 32'h0000_007F, 1'b1, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL lw_misalign got %h want %h", obs, exp_v); end
    accept_load(5'd8, 3'b011, 2'd0);
    respond(32'h2222_2222);
    exp_v = {1'b1, 1'b0, 5'd8, 32'h0000_007F, 1'b1, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL illegal_f3 got %h want %h", obs, exp_v); end
    accept_load(5'd9, 3'b001, 2'd3);
    respond(32'h3333_3333);
    exp_v = {1'b1, 1'b0, 5'd9, 32'h0000_007F, 1'b1, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL lh_misalign got %h want %h", obs, exp_v); end
    accept_load(5'd0, 3'b010, 2'd0);
    respond(32'h0000_0005);
    exp_v = {1'b1, 1'b0, 5'd0, 32'h0000_0005, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL lw_rd0 got %h want %h", obs, exp_v); end
  endtask

  task automatic test_reset_mid_load();
    accept_load(5'd10, 3'b000, 2'd0);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    exp_v = {1'b1, 1'b0, 5'd0, 32'h0000_0000, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL rst_mid got %h want %h", obs, exp_v); end
    respond(32'h0000_00AA);
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL rst_late_rvalid got %h want %h", obs, exp_v); end
  endtask

`ifdef WB_TIMEOUT_EN
  task automatic test_timeout();
    accept_load(5'd9, 3'b000, 2'd0);
    exp_v = {1'b0, 1'b0, 5'd0, 32'h0000_0000, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("[TB] FAIL tmo_wait%0d got %h want %h", i, obs, exp_v); end
    end
    tick();
    exp_v = {1'b1, 1'b0, 5'd9, 32'h0000_0000, 1'b1, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL tmo_fire got %h want %h", obs, exp_v); end
    accept_load(5'd11, 3'b100, 2'd0);
    tick();
    tick();
    tick();
    respond(32'h0000_00F0);
    exp_v = {1'b1, 1'b1, 5'd11, 32'h0000_00F0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL tmo_limit_resp got %h want %h", obs, exp_v); end
  endtask
`else
  task automatic test_long_wait();
    accept_load(5'd9, 3'b000, 2'd0);
    exp_v = {1'b0, 1'b0, 5'd0, 32'h0000_0000, 1'b0, 1'b0};
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("[TB] FAIL long_wait%0d got %h want %h", i, obs, exp_v); end
    end
    respond(32'h0000_0081);
    exp_v = {1'b1, 1'b1, 5'd9, 32'hFFFF_FF81, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("[TB] FAIL long_resp got %h want %h", obs, exp_v); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_rvalid_idle();
    test_load_byte();
    test_load_half_word();
    test_load_error();
    test_reset_mid_load();
`ifdef WB_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
